perceptron_trainer: RTL and testbench

Training engine for the perceptron branch predictor. It accepts one resolved-branch record at a time and reads the matching weight row from the flattened weight-table bus. It recomputes the perceptron output serially and decides whether training is required. When it is, it emits the saturated new row on the write side (`o_errWeightPos_8` / `o_newWeights_72`) that the branch-table block commits. It is the producer and writer for the weight table, which the table block stores and exports.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/sat_step8.sv | 26 ++
 rtl/perceptron_trainer.sv | 161 ++++++++++++++++
 tb/tb_perceptron_trainer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants, FSM state type and PC-to-row mapping for the perceptron
// branch predictor blocks.
package bp_pkg;

    localparam int ROWS_C   = 228;
    localparam int NW_C     = 9;
    localparam int WEIGHT_W = 8;
    localparam int ACC_W    = 12;
    localparam int THETA_C  = 29;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SUM    = 3'd2,
        DECIDE = 3'd3,
        WRITE  = 3'd4
    } state_t;

    // PC[9:2] folded into the 228-entry table by a single conditional subtract.
    function automatic logic [7:0] row_index(input logic [31:0] pc);
        logic [7:0] p;
        p = pc[9:2];
        if (p >= 8'(ROWS_C)) begin
            row_index = p - 8'(ROWS_C);
        end else begin
            row_index = p;
        end
    endfunction

endpackage

// File: rtl/sat_step8.sv
// Signed 8-bit weight step of +1/-1 that holds at the -128/+127 rails.
module sat_step8 (
    input  logic [7:0] i_w,
    input  logic       i_inc,
    output logic [7:0] o_w
);

    // Step the weight, clamping at the signed rails.
    always_comb begin
        o_w = i_w;
        if (i_inc) begin
            if (i_w == 8'h7F) begin
                o_w = i_w;
            end else begin
                o_w = i_w + 8'd1;
            end
        end else begin
            if (i_w == 8'h80) begin
                o_w = i_w;
            end else begin
                o_w = i_w - 8'd1;
            end
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training engine: serial dot product, train decision, saturated row write.
// Optional BP_TRAIN_STATS_EN adds mispredict/train event counters.
module perceptron_trainer
    import bp_pkg::*;
#(
    parameter int ROWS  = ROWS_C,
    parameter int THETA = THETA_C
) (
    input  logic               fire,
    input  logic               rst,
    input  logic               i_resValid_1,
    output logic               o_resReady_1,
    input  logic [31:0]        i_resPC_32,
    input  logic               i_resTaken_1,
    input  logic [7:0]         i_resHist_8,
    input  logic [ROWS*72-1:0] i_weightTable_16416,
    output logic               o_wrValid_1,
    input  logic               i_wrReady_1,
    output logic [7:0]         o_errWeightPos_8,
`ifdef BP_TRAIN_STATS_EN
    output logic [15:0]        o_mispredCnt_16,
    output logic [15:0]        o_trainCnt_16,
`endif
    output logic [71:0]        o_newWeights_72
);

    state_t                   r_state;
    logic [7:0]               r_idx;
    logic                     r_taken;
    logic [7:0]               r_hist;
    logic [71:0]              r_row;
    logic signed [ACC_W-1:0]  r_acc;
    logic [3:0]               r_k;

    logic [8:0]               w_xbits;
    logic [14:0]              w_base;
    logic [7:0]               w_wk;
    logic signed [ACC_W-1:0]  w_term;
    logic                     w_mispred;
    logic                     w_small;
    logic                     w_train;
    logic [71:0]              w_new;

    // Bit k is 1 when x_k = +1; the bias input is always +1.
    assign w_xbits = {r_hist, 1'b1};
    assign w_base  = 15'(r_idx) * 15'd72;

    // Signed contribution x_k * w_k for the current SUM step.
    always_comb begin
        w_wk   = r_row[{r_k[2:0], 3'b000} +: 8];
        w_term = 12'sd0;
        if (r_k == 4'd8) begin
            w_wk = r_row[71:64];
        end else begin
            w_wk = r_row[{r_k[2:0], 3'b000} +: 8];
        end
        if (w_xbits[r_k]) begin
            w_term = $signed({{4{w_wk[7]}}, w_wk});
        end else begin
            w_term = 12'sd0 - $signed({{4{w_wk[7]}}, w_wk});
        end
    end

    assign w_mispred = (~r_acc[ACC_W-1]) != r_taken;
    assign w_small   = (r_acc <= $signed(12'(THETA))) && (r_acc >= -$signed(12'(THETA)));
    assign w_train   = w_mispred || w_small;

    genvar g;
    generate
        for (g = 0; g < NW_C; g++) begin : g_sat
            sat_step8 u_sat (
                .i_w   (r_row[g*8 +: 8]),
                .i_inc (w_xbits[g] == r_taken),
                .o_w   (w_new[g*8 +: 8])
            );
        end
    endgenerate

    // Trainer FSM with registered handshake outputs.
    always_ff @(posedge fire) begin
        if (rst) begin
            r_state          <= IDLE;
            r_idx            <= 8'd0;
            r_taken          <= 1'b0;
            r_hist           <= 8'd0;
            r_row            <= 72'd0;
            r_acc            <= 12'sd0;
            r_k              <= 4'd0;
            o_resReady_1     <= 1'b1;
            o_wrValid_1      <= 1'b0;
            o_errWeightPos_8 <= 8'd0;
            o_newWeights_72  <= 72'd0;
`ifdef BP_TRAIN_STATS_EN
            o_mispredCnt_16  <= 16'd0;
            o_trainCnt_16    <= 16'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_resValid_1 && o_resReady_1) begin
                        r_idx        <= row_index(i_resPC_32);
                        r_taken      <= i_resTaken_1;
                        r_hist       <= i_resHist_8;
                        o_resReady_1 <= 1'b0;
                        r_state      <= LOAD;
                    end else begin
                        r_state      <= IDLE;
                    end
                end
                LOAD: begin
                    r_row   <= i_weightTable_16416[w_base +: 72];
                    r_acc   <= 12'sd0;
                    r_k     <= 4'd0;
                    r_state <= SUM;
                end
                SUM: begin
                    r_acc <= r_acc + w_term;
                    if (r_k == 4'd8) begin
                        r_state <= DECIDE;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                DECIDE: begin
`ifdef BP_TRAIN_STATS_EN
                    if (w_mispred && (o_mispredCnt_16 != 16'hFFFF)) begin
                        o_mispredCnt_16 <= o_mispredCnt_16 + 16'd1;
                    end
                    if (w_train && (o_trainCnt_16 != 16'hFFFF)) begin
                        o_trainCnt_16 <= o_trainCnt_16 + 16'd1;
                    end
`endif
                    if (w_train) begin
                        o_newWeights_72  <= w_new;
                        o_errWeightPos_8 <= r_idx;
                        o_wrValid_1      <= 1'b1;
                        r_state          <= WRITE;
                    end else begin
                        o_resReady_1     <= 1'b1;
                        r_state          <= IDLE;
                    end
                end
                WRITE: begin
                    if (i_wrReady_1) begin
                        o_wrValid_1  <= 1'b0;
                        o_resReady_1 <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_state      <= WRITE;
                    end
                end
                default: begin
                    o_wrValid_1  <= 1'b0;
                    o_resReady_1 <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Randomized bench for perceptron_trainer against an arithmetic perceptron model.
module tb_perceptron_trainer;

    localparam int ROWS  = 228;
    localparam int THETA = 29;

    logic               fire = 1'b0;
    logic               rst;
    logic               i_resValid_1;
    logic               o_resReady_1;
    logic [31:0]        i_resPC_32;
    logic               i_resTaken_1;
    logic [7:0]         i_resHist_8;
    logic [ROWS*72-1:0] tbl;
    logic               o_wrValid_1;
    logic               i_wrReady_1;
    logic [7:0]         o_errWeightPos_8;
    logic [71:0]        o_newWeights_72;
`ifdef BP_TRAIN_STATS_EN
    logic [15:0]        mispred_cnt;
    logic [15:0]        train_cnt;
`endif

    int          wt [ROWS][9];
    int          errors = 0;
    int          checks = 0;
    logic [71:0] last_row;
    logic [7:0]  last_idx;

    always #5 fire = ~fire;

    perceptron_trainer dut (
        .fire                (fire),
        .rst                 (rst),
        .i_resValid_1        (i_resValid_1),
        .o_resReady_1        (o_resReady_1),
        .i_resPC_32          (i_resPC_32),
        .i_resTaken_1        (i_resTaken_1),
        .i_resHist_8         (i_resHist_8),
        .i_weightTable_16416 (tbl),
        .o_wrValid_1         (o_wrValid_1),
        .i_wrReady_1         (i_wrReady_1),
        .o_errWeightPos_8    (o_errWeightPos_8),
`ifdef BP_TRAIN_STATS_EN
        .o_mispredCnt_16     (mispred_cnt),
        .o_trainCnt_16       (train_cnt),
`endif
        .o_newWeights_72     (o_newWeights_72)
    );

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rebuild_bus();
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < 9; k++) begin
                tbl[r*72 + k*8 +: 8] = 8'(wt[r][k]);
            end
        end
    endtask

    task automatic fill_row(input int r, input int v);
        for (int k = 0; k < 9; k++) wt[r][k] = v;
        rebuild_bus();
    endtask

    // One record end to end: accept, latency, decision, write handshake.
    task automatic run_record(input logic [31:0] pc, input logic tk, input logic [7:0] h, input int stall);
        int          r, y, n, x, tt, v;
        int          nw [9];
        logic        exp_train;
        logic [71:0] exp_row;
        logic [71:0] held;
        r = ((pc >> 2) & 255) % ROWS;
        y = wt[r][0];
        for (int k = 1; k < 9; k++) y += h[k-1] ? wt[r][k] : -wt[r][k];
        exp_train = ((y >= 0) != tk) || (y <= THETA && y >= -THETA);
        tt = tk ? 1 : -1;
        for (int k = 0; k < 9; k++) begin
            x = (k == 0) ? 1 : (h[k-1] ? 1 : -1);
            v = wt[r][k] + ((x == tt) ? 1 : -1);
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            nw[k] = v;
            exp_row[k*8 +: 8] = 8'(v);
        end
        @(negedge fire);
        i_resValid_1 = 1'b1;
        i_resPC_32   = pc;
        i_resTaken_1 = tk;
        i_resHist_8  = h;
        n = 0;
        while (!o_resReady_1 && n < 40) begin
            @(negedge fire);
            n++;
        end
        check_eq("ready_before_accept", 72'(o_resReady_1), 72'd1);
        @(posedge fire);
        #1 i_resValid_1 = 1'b0;
        @(negedge fire);
        check_eq("busy_after_accept", 72'(o_resReady_1), 72'd0);
        n = 0;
        while (!o_wrValid_1 && !o_resReady_1 && n < 40) begin
            @(negedge fire);
            n++;
        end
        check_eq("latency", 72'(n), 72'd11);
        held = o_newWeights_72;
        if (exp_train) begin
            check_eq("wr_valid", 72'(o_wrValid_1), 72'd1);
            check_eq("wr_index", 72'(o_errWeightPos_8), 72'(r));
            check_eq("wr_row", o_newWeights_72, exp_row);
            for (int s = 0; s < stall; s++) begin
                @(negedge fire);
                check_eq("stall_data", o_newWeights_72, held);
                check_eq("stall_ready", 72'(o_resReady_1), 72'd0);
                check_eq("stall_valid", 72'(o_wrValid_1), 72'd1);
            end
            i_wrReady_1 = 1'b1;
            @(posedge fire);
            #1 i_wrReady_1 = 1'b0;
            @(negedge fire);
            check_eq("wr_done_valid", 72'(o_wrValid_1), 72'd0);
            check_eq("wr_done_ready", 72'(o_resReady_1), 72'd1);
            for (int k = 0; k < 9; k++) wt[r][k] = nw[k];
            rebuild_bus();
        end else begin
            check_eq("no_write", 72'(o_wrValid_1), 72'd0);
            check_eq("no_train_ready", 72'(o_resReady_1), 72'd1);
        end
        last_row = held;
        last_idx = o_errWeightPos_8;
    endtask

    initial begin
        int saw_wr;
        rst          = 1'b1;
        i_resValid_1 = 1'b0;
        i_resPC_32   = 32'd0;
        i_resTaken_1 = 1'b0;
        i_resHist_8  = 8'd0;
        i_wrReady_1  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < 9; k++) wt[r][k] = int'($urandom_range(0, 60)) - 30;
        end
        rebuild_bus();
        repeat (3) @(negedge fire);
        check_eq("rst_ready", 72'(o_resReady_1), 72'd1);
        check_eq("rst_valid", 72'(o_wrValid_1), 72'd0);
        check_eq("rst_index", 72'(o_errWeightPos_8), 72'd0);
        check_eq("rst_row", o_newWeights_72, 72'd0);
        rst = 1'b0;

        fill_row(0, 0);
        run_record(32'h0, 1'b1, 8'hFF, 0);
        check_eq("zero_row_index", 72'(last_idx), 72'd0);
        check_eq("zero_row_data", last_row, 72'h01_01_01_01_01_01_01_01_01);

        fill_row(5, 127);
        run_record(32'h14, 1'b1, 8'hFF, 0);

        fill_row(7, -128);
        run_record(32'h1C, 1'b0, 8'h00, 2);
        check_eq("rail_row_data", last_row, 72'h81_81_81_81_81_81_81_81_80);

        fill_row(2, 0);
        run_record(32'h398, 1'b1, 8'h5A, 5);
        check_eq("wrap_index", 72'(last_idx), 72'd2);

        // Reset while summing at k=4: the record must vanish without a write.
        fill_row(9, 0);
        @(negedge fire);
        i_resValid_1 = 1'b1;
        i_resPC_32   = 32'h24;
        i_resTaken_1 = 1'b1;
        i_resHist_8  = 8'h00;
        @(posedge fire);
        #1 i_resValid_1 = 1'b0;
        repeat (6) @(negedge fire);
        rst = 1'b1;
        @(posedge fire);
        #1 rst = 1'b0;
        @(negedge fire);
        check_eq("mid_rst_ready", 72'(o_resReady_1), 72'd1);
        check_eq("mid_rst_valid", 72'(o_wrValid_1), 72'd0);
        saw_wr = 0;
        repeat (15) begin
            @(negedge fire);
            if (o_wrValid_1) saw_wr = 1;
        end
        check_eq("mid_rst_no_write", 72'(saw_wr), 72'd0);
        run_record(32'h24, 1'b1, 8'h00, 0);

        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) fill_row(int'($urandom_range(0, ROWS - 1)), ($urandom_range(0, 1) == 1) ? 127 : -128);
            run_record($urandom, 1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
